ex_div_unit: RTL and testbench
==============================

# ex_div_unit

Iterative radix-2 divider for the RV32M DIV, DIVU, REM and REMU instructions. It sits in the EX stage directly downstream of the EX operand-forwarding muxes and consumes the forwarded operand values. It holds the pipeline with a stall request while it iterates. It returns one 32-bit result per instruction alongside the single-cycle ALU result.

## Interface
- Parameters: none. The iteration count is fixed at 32.
- CLK  input  1  pipeline clock; all state updates on the rising edge
- RESET  input  1  synchronous, active-high reset
- START  input  1  level; high while a divide-class instruction occupies EX and its forwarded operands are valid
- OP  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU; sampled with START
- DATA1  input  32  dividend, post-forwarding
- DATA2  input  32  divisor, post-forwarding
- FLUSH  input  1  abort the current operation (branch/jump redirect)
- RESULT  output  32  quotient or remainder; registered; held until the next completion
- DONE  output  1  registered; high for exactly one cycle when RESULT is valid
- BUSY  output  1  combinational stall request to the hazard/pipeline-register logic

## Operation
- States: IDLE, CALC, FIN.
- IDLE, with START=1 and FLUSH=0:
  - Latch OP, the sign flags, |DATA1| and |DATA2|. Magnitudes apply only for DIV/REM; DIVU/REMU use raw values.
  - Divisor == 0 goes to FIN with the special result.
  - DIV/REM with DATA1 = 0x80000000 and DATA2 = 0xFFFFFFFF goes to FIN with the special result.
  - Otherwise clear the 6-bit iteration counter and go to CALC.
- CALC: one restoring step per cycle.
  - Shift the {remainder, quotient} 64-bit register left by 1.
  - Trial-subtract the divisor from the upper 33 bits. If the result is non-negative, commit it and set quotient bit 0.
  - After the 32nd step, go to FIN.
- FIN:
  - Set DONE=1 and load RESULT.
  - Quotient sign: negate if the dividend and divisor signs differ (signed ops only).
  - Remainder sign: takes the sign of the dividend.
  - Always return to IDLE next cycle. START is ignored in FIN because the same instruction is still in EX.
- Special results (RISC-V spec):
  - Divide by zero: DIV/DIVU give 0xFFFFFFFF; REM/REMU give DATA1.
  - Signed overflow: DIV gives 0x80000000; REM gives 0.
- BUSY = (IDLE and START and not FLUSH) or CALC. BUSY is 0 in FIN, so the pipeline advances on the FIN edge and captures RESULT.
- FLUSH=1 in any state: next state IDLE, DONE=0, RESULT unchanged. FLUSH takes priority over START.
- All arithmetic is unsigned on magnitudes. Negation is two's complement at 32 bits; |0x80000000| is treated as an unsigned 0x80000000.

## Timing
- Reset values: state IDLE, RESULT=0, DONE=0, counter=0, shift register=0. BUSY=0 while RESET=1.
- RESET mid-CALC: abandons the operation; no DONE is produced.
- Normal latency: START seen in cycle 0, CALC cycles 1–32, FIN/DONE in cycle 33. BUSY is high in cycles 0–32.
- Special-case latency: DONE in cycle 1; BUSY high in cycle 0 only.
- Back-to-back divides: the second START is accepted in the IDLE cycle after FIN, giving 34 cycles per normal divide.
- OP, DATA1 and DATA2 are sampled only in the IDLE→CALC/FIN cycle. Later changes (e.g. forwarding sources retiring) have no effect.

## Test plan
- DIVU, DATA1=100, DATA2=7, START held -> BUSY high in cycles 0–32; DONE=1 in cycle 33 only, RESULT=14. Repeat with REMU -> RESULT=2.
- DIV -7/2 -> 0xFFFFFFFD (−3). REM -7/2 -> 0xFFFFFFFF (−1). REM 7/-2 -> 1.
- DIV 5/0 -> 0xFFFFFFFF with DONE in cycle 1. REMU 5/0 -> 5. DIV 0x80000000/0xFFFFFFFF -> 0x80000000. REM of the same -> 0.
- Two consecutive DIVU instructions (1000/10, then 81/9) with START held through FIN -> exactly two DONE pulses (cycles 33 and 67), RESULT 100 then 9. No extra DONE from START during FIN.
- FLUSH in CALC cycle 10 -> IDLE next cycle, BUSY=0, no DONE, RESULT retains its prior value. Then a new DIVU 9/3 -> 3.
- RESET asserted in CALC cycle 20 -> next cycle state IDLE, RESULT=0, DONE=0, BUSY=0. A subsequent DIVU completes normally.

Source files
------------

// File: rtl/ex_div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle; stalls the pipeline through BUSY while iterating.
module ex_div_unit (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        START,
  input  logic [1:0]  OP,
  input  logic [31:0] DATA1,
  input  logic [31:0] DATA2,
  input  logic        FLUSH,
  output logic [31:0] RESULT,
  output logic        DONE,
  output logic        BUSY
);

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t      state_reg, state_next;
  logic [1:0]  op_reg, op_next;
  logic        neg_q_reg, neg_q_next;
  logic        neg_r_reg, neg_r_next;
  logic [31:0] divisor_reg, divisor_next;
  logic [63:0] acc_reg, acc_next;
  logic [5:0]  count_reg, count_next;
  logic [31:0] result_reg, result_next;
  logic        done_reg, done_next;
  logic        busy_comb;

  logic        is_signed, sign1, sign2, overflow;
  logic [31:0] mag1, mag2;
  logic [32:0] trial_upper;
  logic        trial_ge;
  logic [31:0] trial_diff;
  logic [63:0] step;
  logic [31:0] quo_fixed, rem_fixed;

  assign is_signed = ~OP[0];
  assign sign1     = is_signed & DATA1[31];
  assign sign2     = is_signed & DATA2[31];
  assign mag1      = sign1 ? (~DATA1 + 32'd1) : DATA1;
  assign mag2      = sign2 ? (~DATA2 + 32'd1) : DATA2;
  assign overflow  = is_signed && (DATA1 == 32'h8000_0000) && (DATA2 == 32'hFFFF_FFFF);

  // Shifted partial remainder can reach 33 bits, but after a successful
  // subtract it is always below the divisor, so 32 bits hold the difference.
  assign trial_upper = acc_reg[63:31];
  assign trial_ge    = trial_upper >= {1'b0, divisor_reg};
  assign trial_diff  = acc_reg[62:31] - divisor_reg;
  assign step        = trial_ge ? {trial_diff, acc_reg[30:0], 1'b1}
                                : {acc_reg[62:0], 1'b0};

  assign quo_fixed = neg_q_reg ? (~step[31:0] + 32'd1) : step[31:0];
  assign rem_fixed = neg_r_reg ? (~step[63:32] + 32'd1) : step[63:32];

  always_comb begin
    state_next   = state_reg;
    op_next      = op_reg;
    neg_q_next   = neg_q_reg;
    neg_r_next   = neg_r_reg;
    divisor_next = divisor_reg;
    acc_next     = acc_reg;
    count_next   = count_reg;
    result_next  = result_reg;
    done_next    = 1'b0;
    busy_comb    = 1'b0;

    case (state_reg)
      IDLE: begin
        if (START && !FLUSH) begin
          busy_comb    = 1'b1;
          op_next      = OP;
          neg_q_next   = sign1 ^ sign2;
          neg_r_next   = sign1;
          divisor_next = mag2;
          acc_next     = {32'd0, mag1};
          count_next   = 6'd0;
          if (DATA2 == 32'd0) begin
            state_next  = FIN;
            done_next   = 1'b1;
            result_next = OP[1] ? DATA1 : 32'hFFFF_FFFF;
          end else if (overflow) begin
            state_next  = FIN;
            done_next   = 1'b1;
            result_next = OP[1] ? 32'd0 : 32'h8000_0000;
          end else begin
            state_next = CALC;
          end
        end
      end
      CALC: begin
        busy_comb  = 1'b1;
        acc_next   = step;
        count_next = count_reg + 6'd1;
        if (count_reg == 6'd31) begin
          state_next  = FIN;
          done_next   = 1'b1;
          result_next = op_reg[1] ? rem_fixed : quo_fixed;
        end
      end
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase

    // A redirect discards whatever is in flight, including a pending result.
    if (FLUSH) begin
      state_next  = IDLE;
      done_next   = 1'b0;
      result_next = result_reg;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_reg   <= IDLE;
      op_reg      <= 2'd0;
      neg_q_reg   <= 1'b0;
      neg_r_reg   <= 1'b0;
      divisor_reg <= 32'd0;
      acc_reg     <= 64'd0;
      count_reg   <= 6'd0;
      result_reg  <= 32'd0;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      op_reg      <= op_next;
      neg_q_reg   <= neg_q_next;
      neg_r_reg   <= neg_r_next;
      divisor_reg <= divisor_next;
      acc_reg     <= acc_next;
      count_reg   <= count_next;
      result_reg  <= result_next;
      done_reg    <= done_next;
    end
  end

  assign RESULT = result_reg;
  assign DONE   = done_reg;
  assign BUSY   = busy_comb & ~RESET;

endmodule

// File: tb/tb_ex_div_unit.sv
// Directed and randomized checks of ex_div_unit against an arithmetic reference model.
module tb_ex_div_unit;

  logic        CLK = 1'b0;
  logic        RESET, START, FLUSH;
  logic [1:0]  OP;
  logic [31:0] DATA1, DATA2, RESULT;
  logic        DONE, BUSY;

  int tests_run = 0;
  int tests_failed = 0;
  logic [31:0] last_result;

  ex_div_unit dut (
    .CLK(CLK), .RESET(RESET), .START(START), .OP(OP),
    .DATA1(DATA1), .DATA2(DATA2), .FLUSH(FLUSH),
    .RESULT(RESULT), .DONE(DONE), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  function automatic logic is_special(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    return (b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : 32'h8000_0000;
    case (op)
      2'd0:    return 32'($signed(a) / $signed(b));
      2'd1:    return a / b;
      2'd2:    return 32'($signed(a) % $signed(b));
      default: return a % b;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issues one instruction at the next negedge and leaves START high afterwards.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input string tag);
    logic [31:0] exp;
    int lat;
    exp = ref_div(op, a, b);
    lat = is_special(op, a, b) ? 1 : 33;
    @(negedge CLK);
    START = 1'b1; OP = op; DATA1 = a; DATA2 = b;
    #1;
    check({tag, "_busy_c0"}, {31'd0, BUSY}, 32'd1);
    check({tag, "_done_c0"}, {31'd0, DONE}, 32'd0);
    for (int k = 1; k <= lat; k++) begin
      @(negedge CLK);
      if (k == 1) begin
        OP = 2'($urandom); DATA1 = $urandom; DATA2 = $urandom;
      end
      #1;
      if (k < lat) begin
        check($sformatf("%s_busy_c%0d", tag, k), {31'd0, BUSY}, 32'd1);
        check($sformatf("%s_done_c%0d", tag, k), {31'd0, DONE}, 32'd0);
      end else begin
        check($sformatf("%s_done_c%0d", tag, k), {31'd0, DONE}, 32'd1);
        check($sformatf("%s_busy_c%0d", tag, k), {31'd0, BUSY}, 32'd0);
        check({tag, "_result"}, RESULT, exp);
      end
    end
    last_result = exp;
    $display("[TB] %s op=%0d a=%h b=%h result=%h expected=%h", tag, op, a, b, RESULT, exp);
  endtask

  task automatic go_idle(input string tag);
    @(negedge CLK);
    START = 1'b0; FLUSH = 1'b0;
    #1;
    check({tag, "_idle_done"}, {31'd0, DONE}, 32'd0);
    check({tag, "_idle_busy"}, {31'd0, BUSY}, 32'd0);
    check({tag, "_idle_result"}, RESULT, last_result);
  endtask

  task automatic quiet_cycles(input int n, input string tag);
    int dones = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge CLK); #1;
      if (DONE === 1'b1) dones++;
    end
    check({tag, "_no_done"}, 32'(dones), 32'd0);
  endtask

  initial begin
    RESET = 1'b1; START = 1'b1; FLUSH = 1'b0; OP = 2'd1; DATA1 = 32'd100; DATA2 = 32'd7;
    last_result = 32'd0;
    @(negedge CLK); #1;
    check("reset_busy", {31'd0, BUSY}, 32'd0);
    @(negedge CLK); #1;
    check("reset_result", RESULT, 32'd0);
    check("reset_done", {31'd0, DONE}, 32'd0);
    RESET = 1'b0; START = 1'b0;
    @(negedge CLK); #1;
    check("post_reset_busy", {31'd0, BUSY}, 32'd0);

    run_op(2'd1, 32'd100, 32'd7, "divu_100_7");   go_idle("divu_100_7");
    run_op(2'd3, 32'd100, 32'd7, "remu_100_7");   go_idle("remu_100_7");
    run_op(2'd0, 32'hFFFF_FFF9, 32'd2, "div_m7_2"); go_idle("div_m7_2");
    check("div_m7_2_const", last_result, 32'hFFFF_FFFD);
    run_op(2'd2, 32'hFFFF_FFF9, 32'd2, "rem_m7_2"); go_idle("rem_m7_2");
    check("rem_m7_2_const", last_result, 32'hFFFF_FFFF);
    run_op(2'd2, 32'd7, 32'hFFFF_FFFE, "rem_7_m2"); go_idle("rem_7_m2");
    check("rem_7_m2_const", last_result, 32'd1);
    run_op(2'd0, 32'd5, 32'd0, "div_by0");   go_idle("div_by0");
    run_op(2'd3, 32'd5, 32'd0, "remu_by0");  go_idle("remu_by0");
    run_op(2'd0, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf"); go_idle("div_ovf");
    run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf"); go_idle("rem_ovf");

    // Back-to-back with START held through FIN.
    run_op(2'd1, 32'd1000, 32'd10, "b2b_first");
    run_op(2'd1, 32'd81, 32'd9, "b2b_second");
    go_idle("b2b_second");

    // Flush in CALC cycle 10.
    @(negedge CLK);
    START = 1'b1; OP = 2'd1; DATA1 = 32'hDEAD_BEEF; DATA2 = 32'd13;
    for (int k = 1; k <= 10; k++) @(negedge CLK);
    FLUSH = 1'b1;
    go_idle("flush");
    quiet_cycles(40, "flush");
    run_op(2'd1, 32'd9, 32'd3, "after_flush"); go_idle("after_flush");

    // Reset in CALC cycle 20.
    @(negedge CLK);
    START = 1'b1; OP = 2'd0; DATA1 = 32'h1234_5678; DATA2 = 32'd77;
    for (int k = 1; k <= 20; k++) @(negedge CLK);
    RESET = 1'b1; START = 1'b0;
    @(negedge CLK); #1;
    check("midreset_busy", {31'd0, BUSY}, 32'd0);
    check("midreset_done", {31'd0, DONE}, 32'd0);
    check("midreset_result", RESULT, 32'd0);
    RESET = 1'b0;
    last_result = 32'd0;
    quiet_cycles(40, "midreset");
    run_op(2'd1, 32'd144, 32'd12, "after_reset"); go_idle("after_reset");

    for (int i = 0; i < 24; i++) begin
      logic [1:0] op;
      logic [31:0] a, b;
      int sel;
      op = 2'($urandom_range(0, 3));
      a = $urandom;
      sel = $urandom_range(0, 9);
      case (sel)
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 15));
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      run_op(op, a, b, $sformatf("rand%0d", i));
      if ($urandom_range(0, 1) == 0) go_idle($sformatf("rand%0d", i));
    end
    go_idle("final");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
